// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO: storage, pointer control, fill count, threshold status and
// sticky error flags, with a choice of registered-read or first-word-fall-through output.
module sync_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADD_WIDTH  = 3,
    parameter int AF_TH      = 6,
    parameter int AE_TH      = 2,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADD_WIDTH:0]    fill_count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADD_WIDTH;

    localparam logic [ADD_WIDTH:0] CNT_ZERO = '0;
    localparam logic [ADD_WIDTH:0] CNT_ONE  = {{ADD_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADD_WIDTH:0] CNT_FULL = {1'b1, {ADD_WIDTH{1'b0}}};
    localparam logic [ADD_WIDTH:0] AF_CNT   = (ADD_WIDTH + 1)'(AF_TH);
    localparam logic [ADD_WIDTH:0] AE_CNT   = (ADD_WIDTH + 1)'(AE_TH);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic [ADD_WIDTH:0]   wr_ptr;
    logic [ADD_WIDTH:0]   rd_ptr;
    logic [ADD_WIDTH-1:0] wr_addr;
    logic [ADD_WIDTH-1:0] rd_addr;
    logic                 wr_acc;
    logic                 rd_acc;

    // Request/accept semantics: wr_en and rd_en are requests sampled at the
    // rising edge. A write is accepted only if the registered fifo_full is low,
    // a read only if the registered fifo_empty is low; a rejected request has
    // no effect other than raising the matching sticky error flag.
    assign wr_acc  = wr_en & ~fifo_full;
    assign rd_acc  = rd_en & ~fifo_empty;
    assign wr_addr = wr_ptr[ADD_WIDTH-1:0];
    assign rd_addr = rd_ptr[ADD_WIDTH-1:0];

    // Pointer MSB is a wrap bit, so both pointers simply roll over modulo 2*DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + CNT_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_count <= CNT_ZERO;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   fill_count <= fill_count + CNT_ONE;
                2'b01:   fill_count <= fill_count - CNT_ONE;
                default: fill_count <= fill_count;
            endcase
        end
    end

    // Storage is deliberately not reset; only accepted writes touch it.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_addr] <= data_in;
        end
    end

    assign fifo_full    = (fill_count == CNT_FULL);
    assign fifo_empty   = (fill_count == CNT_ZERO);
    assign almost_full  = (fill_count >= AF_CNT);
    assign almost_empty = (fill_count <= AE_CNT);

    // A new error event in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en & fifo_full) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (rd_en & fifo_empty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is always presented; rd_en acknowledges and pops it.
            assign data_out   = mem[rd_addr];
            assign data_valid = ~fifo_empty;
        end else begin : g_std
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_out   <= '0;
                    data_valid <= 1'b0;
                end else begin
                    data_valid <= rd_acc;
                    if (rd_acc) begin
                        data_out <= mem[rd_addr];
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl: one instance in registered-read mode and
// one in first-word-fall-through mode, driven from shared stimulus.
module tb_sync_fifo_ctrl;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] data_in;
    logic       rd_en;
    logic       err_clr;

    logic [7:0] s_data_out, f_data_out;
    logic       s_data_valid, f_data_valid;
    logic       s_full, f_full;
    logic       s_empty, f_empty;
    logic       s_afull, f_afull;
    logic       s_aempty, f_aempty;
    logic [3:0] s_count, f_count;
    logic       s_ovf, f_ovf;
    logic       s_udf, f_udf;

    int n_checks;
    int n_fail;
    logic [7:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    sync_fifo_ctrl #(.DATA_WIDTH(8), .ADD_WIDTH(3), .AF_TH(6), .AE_TH(2), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .err_clr(err_clr), .data_out(s_data_out), .data_valid(s_data_valid),
        .fifo_full(s_full), .fifo_empty(s_empty), .almost_full(s_afull),
        .almost_empty(s_aempty), .fill_count(s_count), .overflow(s_ovf),
        .underflow(s_udf)
    );

    sync_fifo_ctrl #(.DATA_WIDTH(8), .ADD_WIDTH(3), .AF_TH(6), .AE_TH(2), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .err_clr(err_clr), .data_out(f_data_out), .data_valid(f_data_valid),
        .fifo_full(f_full), .fifo_empty(f_empty), .almost_full(f_afull),
        .almost_empty(f_aempty), .fill_count(f_count), .overflow(f_ovf),
        .underflow(f_udf)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic pop_exp(output logic [7:0] v);
        if (exp_q.size() == 0) begin
            check("exp_q_nonempty", 32'd0, 32'd1);
            v = 8'h00;
        end else begin
            v = exp_q.pop_front();
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] d);
        wr_en   = 1'b1;
        data_in = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic do_read_std(input string tag);
        logic [7:0] e;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        pop_exp(e);
        check({tag, "_data"}, s_data_out, e);
        check({tag, "_valid"}, s_data_valid, 1);
        tick();
        check({tag, "_valid_pulse"}, s_data_valid, 0);
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    task automatic apply_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) tick();
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] e;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        err_clr  = 1'b0;
        data_in  = 8'h00;

        // Reset
        apply_reset(2);
        tick();
        check("rst_count", s_count, 0);
        check("rst_empty", s_empty, 1);
        check("rst_aempty", s_aempty, 1);
        check("rst_full", s_full, 0);
        check("rst_afull", s_afull, 0);
        check("rst_valid", s_data_valid, 0);
        check("rst_data", s_data_out, 0);
        check("rst_ovf", s_ovf, 0);
        check("rst_udf", s_udf, 0);

        // Fill 0x10..0x17, status after each edge
        for (int i = 0; i < 8; i++) begin
            do_write(8'h10 + 8'(i));
            exp_q.push_back(8'h10 + 8'(i));
            check("fill_count", s_count, i + 1);
            check("fill_afull", s_afull, (i + 1 >= 6));
            check("fill_aempty", s_aempty, (i + 1 <= 2));
            check("fill_full", s_full, (i == 7));
            check("fill_empty", s_empty, 0);
        end

        // Write into a full FIFO is rejected
        do_write(8'hAA);
        check("ovf_set", s_ovf, 1);
        check("ovf_count", s_count, 8);
        check("ovf_udf", s_udf, 0);

        // Drain; 0xAA must never appear
        for (int i = 0; i < 8; i++) begin
            do_read_std("drain");
            check("drain_count", s_count, 7 - i);
        end
        check("drain_empty", s_empty, 1);
        check("drain_ovf_sticky", s_ovf, 1);

        // Read from empty
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("udf_set", s_udf, 1);
        check("udf_valid", s_data_valid, 0);
        check("udf_count", s_count, 0);

        clear_errors();
        check("clr_ovf", s_ovf, 0);
        check("clr_udf", s_udf, 0);

        // Simultaneous read/write at count 4
        for (int i = 0; i < 4; i++) begin
            do_write(8'h20 + 8'(i));
            exp_q.push_back(8'h20 + 8'(i));
        end
        check("sim4_count_pre", s_count, 4);
        for (int i = 0; i < 5; i++) begin
            wr_en   = 1'b1;
            rd_en   = 1'b1;
            data_in = 8'h30 + 8'(i);
            tick();
            pop_exp(e);
            exp_q.push_back(8'h30 + 8'(i));
            check("sim4_data", s_data_out, e);
            check("sim4_valid", s_data_valid, 1);
            check("sim4_count", s_count, 4);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) do_read_std("sim4_drain");
        check("sim4_empty", s_empty, 1);

        // Simultaneous at empty: write wins, underflow set
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        data_in = 8'h40;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        exp_q.push_back(8'h40);
        check("sim0_count", s_count, 1);
        check("sim0_udf", s_udf, 1);
        check("sim0_valid", s_data_valid, 0);
        clear_errors();

        // Simultaneous at full: read wins, overflow set
        for (int i = 1; i < 8; i++) begin
            do_write(8'h40 + 8'(i));
            exp_q.push_back(8'h40 + 8'(i));
        end
        check("sim8_full_pre", s_full, 1);
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        data_in = 8'h99;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        pop_exp(e);
        check("sim8_count", s_count, 7);
        check("sim8_ovf", s_ovf, 1);
        check("sim8_data", s_data_out, e);
        check("sim8_valid", s_data_valid, 1);
        tick();
        for (int i = 0; i < 7; i++) do_read_std("sim8_drain");
        check("sim8_empty", s_empty, 1);
        clear_errors();

        // Wrap-around: 20 writes, count kept at 1..3
        for (int i = 0; i < 3; i++) begin
            do_write(8'h60 + 8'(i));
            exp_q.push_back(8'h60 + 8'(i));
        end
        for (int i = 3; i < 20; i++) begin
            wr_en   = 1'b1;
            rd_en   = 1'b1;
            data_in = 8'h60 + 8'(i);
            tick();
            pop_exp(e);
            exp_q.push_back(8'h60 + 8'(i));
            check("wrap_data", s_data_out, e);
            check("wrap_count", s_count, 3);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) do_read_std("wrap_drain");
        check("wrap_empty", s_empty, 1);
        check("wrap_ovf", s_ovf, 0);
        check("wrap_udf", s_udf, 0);
        check("wrap_q_drained", exp_q.size(), 0);

        // FWFT mode
        apply_reset(1);
        check("fw_rst_empty", f_empty, 1);
        check("fw_rst_valid", f_data_valid, 0);
        do_write(8'h5A);
        check("fw_first_valid", f_data_valid, 1);
        check("fw_first_data", f_data_out, 8'h5A);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("fw_pop_empty", f_empty, 1);
        check("fw_pop_valid", f_data_valid, 0);
        for (int i = 0; i < 4; i++) do_write(8'h61 + 8'(i));
        check("fw_head", f_data_out, 8'h61);
        check("fw_count4", f_count, 4);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("fw_next_head", f_data_out, 8'h62);
        check("fw_count3", f_count, 3);
        check("fw_valid3", f_data_valid, 1);
        apply_reset(1);
        check("fw_midrst_empty", f_empty, 1);
        check("fw_midrst_count", f_count, 0);
        check("fw_midrst_valid", f_data_valid, 0);
        check("fw_midrst_afull", f_afull, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
